// File: rtl/fetch_redirect_if.sv
// Instruction-memory fetch bus used by fetch_redirect.
//   rd    : fetch request, held with addr stable until done
//   addr  : word fetch address
//   rdata : returned instruction, valid when done=1
//   done  : request complete (may coincide with the first cycle of rd)
// Handshake: a request starts in any cycle with rd=1 and no request pending;
// it completes in the first cycle with rd=1 and done=1 (possibly the same
// cycle). Between start and completion rd stays high and addr does not move.
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_redirect_if;
  logic        rd;
  logic [15:0] addr;
  logic [15:0] rdata;
  logic        done;

  modport master (output rd, output addr, input rdata, input done);
  modport slave  (input rd, input addr, output rdata, output done);
endinterface

// File: rtl/fetch_redirect.sv
// Instruction-fetch front end: owns the PC, issues word fetches over the
// imem bus, parks one returned instruction while decode is stalled, squashes
// wrong-path work on a taken branch/jump, and freezes after delivering HALT.
// Optional macro FETCH_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   redirect_valid  : execute resolved a taken branch/jump this cycle
//   redirect_pc     : target PC (used unmodified)
//   stall           : hazard unit holds IF/ID
//   imem            : fetch bus (master side)
//   if_instr        : IF/ID instruction (NOP_INSTR when if_valid=0)
//   if_pc_plus2     : IF/ID PC+2 of the held instruction
//   if_valid        : IF/ID holds a real instruction
//   flush_id        : kill the instruction in decode (combinational)
//   halted          : fetch frozen by HALT
//   perf_fetched    : delivered-instruction count (0 without FETCH_PERF_EN)
//   perf_squashed   : squash-cycle count (0 without FETCH_PERF_EN)
module fetch_redirect #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [15:0]             redirect_pc,
  input  logic                    stall,
  fetch_redirect_if.master        imem,
  output logic [15:0]             if_instr,
  output logic [15:0]             if_pc_plus2,
  output logic                    if_valid,
  output logic                    flush_id,
  output logic                    halted,
  output logic [15:0]             perf_fetched,
  output logic [15:0]             perf_squashed
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_DROP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, req_addr, pc_plus2;
  logic        skid_valid;
  logic [15:0] skid_instr, skid_pc2;

  logic redirect, resp, deliver_skid, deliver_resp, to_skid, halt_deliver;
  logic skid_is_halt, rdata_is_halt;

  assign redirect      = redirect_valid & ~rst;
  assign flush_id      = redirect;
  assign halted        = (state == S_HALTED);
  assign pc_plus2      = pc + 16'd2;
  assign skid_is_halt  = (skid_instr[15:11] == 5'b00000);
  assign rdata_is_halt = (imem.rdata[15:11] == 5'b00000);

  // In DROP the bus must keep presenting the abandoned address while pc
  // already points at the redirect target, so the issued address is latched.
  assign imem.addr = (state == S_FETCH) ? pc : req_addr;

  always_comb begin
    imem.rd = 1'b0;
    case (state)
      // A full skid blocks new requests unless it drains this cycle; a
      // parked HALT never lets the next request out.
      S_FETCH:  imem.rd = skid_valid ? (~stall & ~skid_is_halt) : 1'b1;
      S_WAIT:   imem.rd = 1'b1;
      S_DROP:   imem.rd = 1'b1;
      S_HALTED: imem.rd = 1'b0;
      default:  imem.rd = 1'b0;
    endcase
    if (rst) imem.rd = 1'b0;
  end

  // A completed request is right-path only outside DROP.
  assign resp         = imem.done & imem.rd & (state != S_DROP);
  assign deliver_skid = ~redirect & ~stall & skid_valid;
  assign deliver_resp = ~redirect & ~stall & ~skid_valid & resp;
  // Parks on stall, or when the skid is draining into IF/ID this cycle.
  assign to_skid      = ~redirect & resp & ~deliver_resp;
  assign halt_deliver = deliver_skid ? skid_is_halt : (deliver_resp & rdata_is_halt);

  always_comb begin
    state_n = state;
    if (redirect) begin
      state_n = (imem.rd & ~imem.done) ? S_DROP : S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (halt_deliver)                state_n = S_HALTED;
          else if (imem.rd & ~imem.done)   state_n = S_WAIT;
        end
        S_WAIT: begin
          if (halt_deliver)                state_n = S_HALTED;
          else if (imem.done)              state_n = S_FETCH;
        end
        S_DROP: begin
          if (imem.done)                   state_n = S_FETCH;
        end
        S_HALTED:                          state_n = S_HALTED;
        default:                           state_n = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc2    <= 16'h0000;
      if_valid    <= 1'b0;
      if_instr    <= NOP_INSTR;
      if_pc_plus2 <= 16'h0000;
    end else begin
      state <= state_n;
      if (state == S_FETCH) req_addr <= pc;

      if (redirect)  pc <= redirect_pc;
      else if (resp) pc <= pc_plus2;

      if (redirect) begin
        skid_valid <= 1'b0;
      end else if (to_skid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem.rdata;
        skid_pc2   <= pc_plus2;
      end else if (deliver_skid) begin
        skid_valid <= 1'b0;
      end

      if (redirect) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end else if (!stall) begin
        if (deliver_skid) begin
          if_valid    <= 1'b1;
          if_instr    <= skid_instr;
          if_pc_plus2 <= skid_pc2;
        end else if (deliver_resp) begin
          if_valid    <= 1'b1;
          if_instr    <= imem.rdata;
          if_pc_plus2 <= pc_plus2;
        end else begin
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetched_cnt, squashed_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_cnt  <= 16'h0000;
      squashed_cnt <= 16'h0000;
    end else begin
      if ((deliver_skid | deliver_resp) && fetched_cnt != 16'hFFFF)
        fetched_cnt <= fetched_cnt + 16'd1;
      if (flush_id && squashed_cnt != 16'hFFFF)
        squashed_cnt <= squashed_cnt + 16'd1;
    end
  end

  assign perf_fetched  = fetched_cnt;
  assign perf_squashed = squashed_cnt;
`else
  assign perf_fetched  = 16'h0000;
  assign perf_squashed = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed steps from reset through zero-wait,
// latency, stall, redirect, HALT and wrap-around, then randomized traffic.
// The reference model is the program-order instruction stream: every valid
// IF/ID load must be mem[pc], pc+2 in sequence from the last redirect target.
module tb_fetch_redirect;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic [15:0] if_instr, if_pc_plus2;
  logic        if_valid, flush_id, halted;
  logic [15:0] perf_fetched, perf_squashed;

  fetch_redirect_if imem ();

  fetch_redirect #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem           (imem),
    .if_instr       (if_instr),
    .if_pc_plus2    (if_pc_plus2),
    .if_valid       (if_valid),
    .flush_id       (flush_id),
    .halted         (halted),
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model and responder state
  logic [15:0] mem [logic [15:0]];
  bit          gen_halt = 1'b0;
  int          fixed_lat = 0;
  bit          busy = 1'b0;
  int          rem = 0;
  logic [15:0] req_a = 16'h0000;

  // reference model state
  logic [31:0] exp_q [$];
  logic [15:0] pc_m = 16'h0000;
  bit          halted_m = 1'b0;
  int          fetched_m = 0;
  int          squashed_m = 0;
  logic        seen_rd;
  logic [15:0] seen_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [15:0] w;
    if (!mem.exists(a)) begin
      w = 16'($urandom);
      if (gen_halt && $urandom_range(0, 29) == 0) w = 16'h0000;
      else if (w[15:11] == 5'b00000) w[15] = 1'b1;
      mem[a] = w;
    end
    return mem[a];
  endfunction

  // One clock cycle: drive inputs, play memory, check, clock, check model.
  task automatic tick(input bit st, input bit rv, input logic [15:0] rpc);
    logic        sv_valid;
    logic [15:0] sv_instr, sv_pc2;
    logic [31:0] e;
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    if (busy) check("rd_held", imem.rd, 1);
    if (halted_m) check("no_fetch_halted", imem.rd, 0);
    seen_rd = imem.rd;
    seen_addr = imem.addr;
    imem.done = 1'b0;
    imem.rdata = 16'($urandom);
    if (imem.rd) begin
      if (!busy) begin
        busy = 1'b1;
        rem = (fixed_lat < 0) ? $urandom_range(0, 3) : fixed_lat;
        req_a = imem.addr;
      end else begin
        check("addr_stable", imem.addr, req_a);
      end
      if (rem == 0) begin
        imem.done = 1'b1;
        imem.rdata = mem_rd(req_a);
        busy = 1'b0;
      end else begin
        rem--;
      end
    end
    #1;
    check("flush_id", flush_id, rv);
    if (rv) squashed_m++;
    sv_valid = if_valid;
    sv_instr = if_instr;
    sv_pc2 = if_pc_plus2;
    @(posedge clk);
    #1;
    if (rv) begin
      check("redirect_valid_clr", if_valid, 0);
      check("redirect_nop", if_instr, NOP);
      exp_q.delete();
      pc_m = rpc;
      halted_m = 1'b0;
    end else if (st) begin
      check("stall_hold_valid", if_valid, sv_valid);
      check("stall_hold_instr", if_instr, sv_instr);
      check("stall_hold_pc2", if_pc_plus2, sv_pc2);
    end else if (if_valid) begin
      if (exp_q.size() == 0) exp_q.push_back({pc_m + 16'd2, mem_rd(pc_m)});
      e = exp_q.pop_front();
      check("deliver_instr", if_instr, e[15:0]);
      check("deliver_pc2", if_pc_plus2, e[31:16]);
      pc_m = pc_m + 16'd2;
      fetched_m++;
      if (e[15:11] == 5'b00000) halted_m = 1'b1;
    end else begin
      check("invalid_nop", if_instr, NOP);
    end
    check("halted", halted, halted_m);
  endtask

  initial begin
    int          f0;
    logic [15:0] x_addr;
    bit          found;

    // clock/reset block
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 16'h1234;
    imem.done = 1'b0;
    imem.rdata = 16'h0000;
    for (int a = 0; a <= 6; a += 2) mem[16'(a)] = 16'h4000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", if_valid, 0);
    check("reset_instr", if_instr, NOP);
    check("reset_pc2", if_pc_plus2, 0);
    check("reset_halted", halted, 0);
    check("reset_rd", imem.rd, 0);
    check("reset_flush", flush_id, 0);
    check("reset_perf_f", perf_fetched, 0);
    check("reset_perf_s", perf_squashed, 0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("first_rd", imem.rd, 1);
    check("first_addr", imem.addr, 16'h0000);

    // zero-wait memory: consecutive addresses, one delivery per cycle
    fixed_lat = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 16'h0000);
      check("zw_addr", seen_addr, 16'(2 * i));
      check("zw_valid", if_valid, 1);
      check("zw_pc2", if_pc_plus2, 16'(2 * i + 2));
    end

    // 3-cycle latency at addr 8
    fixed_lat = 2;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 16'h0000);
      check("lat_rd", seen_rd, 1);
      check("lat_addr", seen_addr, 16'h0008);
      check("lat_valid", if_valid, (i == 2) ? 1 : 0);
    end
    check("lat_pc2", if_pc_plus2, 16'h000A);

    // stall while a fetch completes: parked in skid, drained on release
    fixed_lat = 0;
    tick(1, 0, 16'h0000);
    check("stall_addr", seen_addr, 16'h000A);
    check("stall_pc2_held", if_pc_plus2, 16'h000A);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 16'h0000);
      check("stall_no_req", seen_rd, 0);
    end
    tick(0, 0, 16'h0000);
    check("release_rd", seen_rd, 1);
    check("release_addr", seen_addr, 16'h000C);
    check("release_valid", if_valid, 1);
    check("release_pc2", if_pc_plus2, 16'h000C);

    // redirect during WAIT: old request finishes, data dropped
    fixed_lat = 2;
    tick(0, 0, 16'h0000);
    x_addr = seen_addr;
    tick(0, 1, 16'h0100);
    tick(0, 0, 16'h0000);
    check("drop_rd", seen_rd, 1);
    check("drop_old_addr", seen_addr, x_addr);
    check("drop_valid", if_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 16'h0000);
      check("redir_addr", seen_addr, 16'h0100);
      check("redir_valid", if_valid, (i == 2) ? 1 : 0);
    end
    check("redir_pc2", if_pc_plus2, 16'h0102);

    // HALT at 0x0010, then resume at 0x0040
    fixed_lat = 0;
    mem[16'h0010] = 16'h0000;
    tick(0, 1, 16'h0010);
    tick(0, 0, 16'h0000);
    check("halt_addr", seen_addr, 16'h0010);
    check("halt_delivered", if_instr, 16'h0000);
    check("halt_valid", if_valid, 1);
    check("halt_pc2", if_pc_plus2, 16'h0012);
    check("halt_flag", halted, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 16'h0000);
      check("halt_no_req", seen_rd, 0);
    end
    tick(0, 1, 16'h0040);
    check("resume_halted", halted, 0);
    tick(0, 0, 16'h0000);
    check("resume_rd", seen_rd, 1);
    check("resume_addr", seen_addr, 16'h0040);

    // wrap-around at 0xFFFE
    mem[16'hFFFE] = 16'h4000;
    tick(0, 1, 16'hFFFE);
    tick(0, 0, 16'h0000);
    check("wrap_req", seen_addr, 16'hFFFE);
    check("wrap_pc2", if_pc_plus2, 16'h0000);
    tick(0, 0, 16'h0000);
    check("wrap_next_addr", seen_addr, 16'h0000);

    // randomized traffic: stalls, redirects, variable latency, HALTs
    gen_halt = 1'b1;
    fixed_lat = -1;
    f0 = fetched_m;
    for (int i = 0; i < 800; i++) begin
      bit          st, rv;
      logic [15:0] t;
      st = ($urandom_range(0, 9) < 3);
      rv = halted_m ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      t = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127) * 2);
      tick(st, rv, t);
    end
    found = (fetched_m - f0) > 40;
    check("random_progress", found, 1);

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, fetched_m[15:0]);
    check("perf_squashed", perf_squashed, squashed_m[15:0]);
`else
    check("perf_fetched_tied", perf_fetched, 0);
    check("perf_squashed_tied", perf_squashed, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
